// File: rtl/tt_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tt_sweep_ctrl
//
// Truth-table sweep sequencer for a combinational function-under-test.
// After an accepted start it applies every input vector 0 .. 2^N_IN-1 on
// `vec`. Each vector is held for SETTLE cycles (WAIT) plus one capture cycle
// (CAPTURE). At the end of the capture cycle the function outputs `f_in` are
// stored into `cap_tbl` and compared against the golden table `exp_tbl`. At
// the end of the sweep, `done` pulses for one cycle and `pass` reports the
// result.
//
// Optional build macro:
//   TT_SWEEP_STOP_ON_FAIL_EN - when defined, the first mismatching vector ends
//                              the sweep immediately. `vec` keeps the failing
//                              vector and unvisited cap_tbl slots stay zero.
//
// Parameters:
//   N_IN   - number of function inputs; the table depth is 2^N_IN
//   N_OUT  - number of function outputs per vector
//   SETTLE - cycles spent in WAIT per vector (must be >= 1)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   start          in   sweep request, sampled only in IDLE
//   f_in           in   [N_OUT]            function outputs for the applied vec
//   exp_tbl        in   [N_OUT*2^N_IN]     golden table, slot k at [k*N_OUT +: N_OUT]
//   vec            out  [N_IN]             applied input vector
//   busy           out                     high in WAIT and CAPTURE
//   done           out                     one-cycle end-of-sweep pulse
//   pass           out                     sweep result, valid from done
//   mismatch_cnt   out  [N_IN+1]           number of mismatching vectors
//   first_fail_idx out  [N_IN]             index of the first mismatch (0 if none)
//   cap_tbl        out  [N_OUT*2^N_IN]     captured table, same packing as exp_tbl
// -----------------------------------------------------------------------------
module tt_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N_OUT-1:0]              f_in,
  input  logic [N_OUT*(2**N_IN)-1:0]    exp_tbl,
  output logic [N_IN-1:0]               vec,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [N_IN:0]                 mismatch_cnt,
  output logic [N_IN-1:0]               first_fail_idx,
  output logic [N_OUT*(2**N_IN)-1:0]    cap_tbl
);

  localparam int TBL_W = N_OUT * (2**N_IN);
  // The settle counter must hold SETTLE itself; keep at least one bit.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX  = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Return the golden slot that belongs to table index `k`.
  function automatic logic [N_OUT-1:0] tbl_slot(
    input logic [TBL_W-1:0] tbl,
    input logic [N_IN-1:0]  k
  );
    tbl_slot = tbl[int'(k) * N_OUT +: N_OUT];
  endfunction

  // Current-state registers.
  state_t              state_r;
  logic [N_IN-1:0]     idx_r;
  logic [CW-1:0]       cnt_r;
  logic [N_IN-1:0]     vec_r;
  logic                busy_r;
  logic                done_r;
  logic                pass_r;
  logic [N_IN:0]       mcnt_r;
  logic [N_IN-1:0]     ffi_r;
  logic [TBL_W-1:0]    cap_r;

  // Next-state values computed by the combinational process.
  state_t              state_s;
  logic [N_IN-1:0]     idx_s;
  logic [CW-1:0]       cnt_s;
  logic [N_IN-1:0]     vec_s;
  logic                busy_s;
  logic                done_s;
  logic                pass_s;
  logic [N_IN:0]       mcnt_s;
  logic [N_IN-1:0]     ffi_s;
  logic [TBL_W-1:0]    cap_s;
  logic                miss_s;
  logic                stop_s;

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    vec_s   = vec_r;
    pass_s  = pass_r;
    mcnt_s  = mcnt_r;
    ffi_s   = ffi_r;
    cap_s   = cap_r;
    miss_s  = 1'b0;
    stop_s  = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          idx_s   = {N_IN{1'b0}};
          vec_s   = {N_IN{1'b0}};
          mcnt_s  = {(N_IN+1){1'b0}};
          ffi_s   = {N_IN{1'b0}};
          cap_s   = {TBL_W{1'b0}};
          pass_s  = 1'b0;
          cnt_s   = SETTLE_LD;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // The counter is loaded with SETTLE on entry, so leaving when it
        // reads 1 gives exactly SETTLE cycles in WAIT.
        if (cnt_r <= CW'(1)) begin
          state_s = ST_CAPTURE;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end

      ST_CAPTURE: begin
        cap_s[int'(idx_r) * N_OUT +: N_OUT] = f_in;
        miss_s = (f_in != tbl_slot(exp_tbl, idx_r));
        if (miss_s) begin
          mcnt_s = mcnt_r + (N_IN+1)'(1);
          if (mcnt_r == {(N_IN+1){1'b0}}) begin
            ffi_s = idx_r;
          end else begin
            ffi_s = ffi_r;
          end
        end else begin
          mcnt_s = mcnt_r;
        end
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        stop_s = miss_s;
`else
        stop_s = 1'b0;
`endif
        if ((idx_r == LAST_IDX) || stop_s) begin
          // pass reflects the count including this final capture.
          pass_s  = (mcnt_s == {(N_IN+1){1'b0}});
          state_s = ST_DONE;
        end else begin
          idx_s   = idx_r + N_IN'(1);
          vec_s   = idx_r + N_IN'(1);
          cnt_s   = SETTLE_LD;
          state_s = ST_WAIT;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the state being entered, so
    // they line up with the state register rather than lagging a cycle.
    busy_s = (state_s == ST_WAIT) || (state_s == ST_CAPTURE);
    done_s = (state_s == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= {N_IN{1'b0}};
      cnt_r   <= {CW{1'b0}};
      vec_r   <= {N_IN{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      mcnt_r  <= {(N_IN+1){1'b0}};
      ffi_r   <= {N_IN{1'b0}};
      cap_r   <= {TBL_W{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      vec_r   <= vec_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
      mcnt_r  <= mcnt_s;
      ffi_r   <= ffi_s;
      cap_r   <= cap_s;
    end
  end

  assign vec            = vec_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign mismatch_cnt   = mcnt_r;
  assign first_fail_idx = ffi_r;
  assign cap_tbl        = cap_r;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tt_sweep_ctrl
//
// Scoreboard bench for tt_sweep_ctrl. The driver pushes the expected result of
// each sweep it launches. Per-DUT monitors pop and compare on every done pulse.
// A second instance runs with SETTLE=3. Both instances see the fxyz function:
// s1 = XNOR(x, y) on f_in[1] and s2 = 1 on f_in[0].
// -----------------------------------------------------------------------------
module tb_tt_sweep_ctrl;

  typedef struct {
    logic        pass;
    logic [3:0]  mcnt;
    logic [2:0]  ffi;
    logic [15:0] cap;
    logic [2:0]  vec;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start3;
  logic [15:0] exp_tbl;
  logic [1:0]  f_in, f_in3;
  logic [2:0]  vec, vec3;
  logic        busy, done, pass, busy3, done3, pass3;
  logic [3:0]  mcnt, mcnt3;
  logic [2:0]  ffi, ffi3;
  logic [15:0] cap, cap3;

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int done_seen = 0, done_seen3 = 0;
  exp_t q[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  assign f_in  = {~(vec[2] ^ vec[1]), 1'b1};
  assign f_in3 = {~(vec3[2] ^ vec3[1]), 1'b1};

  tt_sweep_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in), .exp_tbl(exp_tbl),
    .vec(vec), .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mcnt),
    .first_fail_idx(ffi), .cap_tbl(cap));

  tt_sweep_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .f_in(f_in3), .exp_tbl(exp_tbl),
    .vec(vec3), .busy(busy3), .done(done3), .pass(pass3), .mismatch_cnt(mcnt3),
    .first_fail_idx(ffi3), .cap_tbl(cap3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor for the SETTLE=1 instance.
  initial begin
    int acc = 0;
    bit in_sweep = 1'b0;
    logic prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_sweep = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (busy && !in_sweep) begin
          in_sweep = 1'b1;
          acc = edge_cnt;
        end
        if (busy && ((edge_cnt - acc) % 2 == 0))
          check("vec_step", vec, (edge_cnt - acc) / 2);
        if (done) begin
          check("done_one_cycle", prev_done, 0);
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no sweep pending (t=%0t)", $time);
          end else begin
            e = q.pop_front();
            check("pass", pass, e.pass);
            check("mismatch_cnt", mcnt, e.mcnt);
            check("first_fail_idx", ffi, e.ffi);
            check("cap_tbl", cap, e.cap);
            check("vec_end", vec, e.vec);
            check("done_latency", edge_cnt - acc, e.lat);
          end
          in_sweep = 1'b0;
          done_seen++;
        end
        prev_done = done;
      end
    end
  end

  // Monitor for the SETTLE=3 instance.
  initial begin
    int acc = 0;
    bit in_sweep = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_sweep = 1'b0;
      end else begin
        if (busy3 && !in_sweep) begin
          in_sweep = 1'b1;
          acc = edge_cnt;
        end
        if (busy3 && ((edge_cnt - acc) % 4 == 0))
          check("vec_step_s3", vec3, (edge_cnt - acc) / 4);
        if (done3) begin
          if (q3.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done_s3: got done=1 expected no sweep pending (t=%0t)", $time);
          end else begin
            e = q3.pop_front();
            check("pass_s3", pass3, e.pass);
            check("mismatch_cnt_s3", mcnt3, e.mcnt);
            check("cap_tbl_s3", cap3, e.cap);
            check("done_latency_s3", edge_cnt - acc, e.lat);
          end
          in_sweep = 1'b0;
          done_seen3++;
        end
      end
    end
  end

  task automatic wait_done(input bit s3, input int budget);
    int target;
    target = (s3 ? done_seen3 : done_seen) + 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if ((s3 ? done_seen3 : done_seen) >= target) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL done_timeout: got no done within %0d cycles expected one", budget);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_vec"}, vec, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_mcnt"}, mcnt, 0);
    check({tag, "_ffi"}, ffi, 0);
    check({tag, "_cap"}, cap, 0);
  endtask

  initial begin
    exp_t good, bad;
    bit hit;
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; exp_tbl = 16'hF55F;
    good = '{pass: 1'b1, mcnt: 4'd0, ffi: 3'd0, cap: 16'hF55F, vec: 3'd7, lat: 16};
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    bad = '{pass: 1'b0, mcnt: 4'd1, ffi: 3'd2, cap: 16'h001F, vec: 3'd2, lat: 6};
`else
    bad = '{pass: 1'b0, mcnt: 4'd2, ffi: 3'd2, cap: 16'hF55F, vec: 3'd7, lat: 16};
`endif
    repeat (2) @(negedge clk);
    #1 check_reset_vals("rst");
    rst_n = 1'b1;

    // Test 1: clean sweep; extra start pulses while busy must be ignored.
    q.push_back(good);
    pulse_start();
    repeat (3) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    wait_done(1'b0, 40);

    // Test 2: golden table wrong in slots 2 and 5; results held after done.
    exp_tbl = 16'hFD7F;
    q.push_back(bad);
    pulse_start();
    wait_done(1'b0, 40);
    repeat (3) @(negedge clk);
    #1 check("pass_held", pass, 0);
    check("mcnt_held", mcnt, bad.mcnt);

    // Test 3: start held high gives back-to-back sweeps, one done each.
    exp_tbl = 16'hF55F;
    q.push_back(good);
    q.push_back(good);
    @(negedge clk);
    #1 start = 1'b1;
    wait_done(1'b0, 40);
    wait_done(1'b0, 40);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 check("no_third_sweep", busy, 0);

    // Test 4: reset while idx=3 discards the sweep, then a clean sweep.
    q.push_back(good);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      #1 hit = (vec == 3'd3);
    end
    check("reached_idx3", hit, 1);
    rst_n = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    #1 check_reset_vals("midrst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("no_done_after_rst", done_seen, 4);
    q.push_back(good);
    pulse_start();
    wait_done(1'b0, 40);

    // Test 6: SETTLE=3 instance, each vector held 4 cycles.
    q3.push_back('{pass: 1'b1, mcnt: 4'd0, ffi: 3'd0, cap: 16'hF55F, vec: 3'd7, lat: 32});
    @(negedge clk);
    #1 start3 = 1'b1;
    @(negedge clk);
    #1 start3 = 1'b0;
    wait_done(1'b1, 60);

    repeat (3) @(negedge clk);
    #1 check("queue_empty", q.size(), 0);
    check("queue3_empty", q3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
